// File: rtl/aes_pipe_pkg.sv
// Shared AES helpers for the round pipeline: S-box, GF(2^8) xtime, MixColumns and one full round.
// State byte i (column-major, row = i%4, col = i/4) sits at bits [127-8*i -: 8].
package aes_pipe_pkg;

   localparam int unsigned AES_W = 128;
   localparam logic [AES_W-1:0] ROUND_KEY_DEFAULT = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;

   // Listed in natural order 0x00..0xff, so entry b lives at packed index 255-b.
   localparam logic [255:0][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[~b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // col[31:24] is row 0 of the column.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] b0, b1, b2, b3;
      b0 = col[31:24];
      b1 = col[23:16];
      b2 = col[15:8];
      b3 = col[7:0];
      return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
              b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
              b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
              xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
   endfunction

   function automatic logic [AES_W-1:0] aes_round(input logic [AES_W-1:0] s,
                                                  input logic [AES_W-1:0] k);
      logic [AES_W-1:0] sb, sr, mc;
      sb = '0;
      sr = '0;
      mc = '0;
      for (int unsigned i = 0; i < 16; i++)
         sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
      for (int unsigned c = 0; c < 4; c++)
         mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
      return mc ^ k;
   endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One registered AES round with shift enable and asynchronous clear.
// Data/tag only load when a valid item enters, so bubbles leave the payload untouched.
module aes_round_stage
   import aes_pipe_pkg::*;
#(
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             v_in,
   input  logic [AES_W-1:0] d_in,
   input  logic [TAG_W-1:0] t_in,
   input  logic [AES_W-1:0] key,
   output logic             v_q,
   output logic [AES_W-1:0] d_q,
   output logic [TAG_W-1:0] t_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= 1'b0;
         d_q <= '0;
         t_q <= '0;
      end else if (en) begin
         v_q <= v_in;
         if (v_in) begin
            d_q <= aes_round(d_in, key);
            t_q <= t_in;
         end
      end
   end

endmodule

// File: rtl/aes_round_pipe.sv
// AES round pipeline with valid/ready flow control, tag tracking and occupancy.
// Optional macro AES_PIPE_SKID_EN adds a 2-entry skid FIFO after the last round stage.
module aes_round_pipe
   import aes_pipe_pkg::*;
#(
   parameter  int unsigned      NUM_ROUNDS = 30,
   parameter  logic [AES_W-1:0] ROUND_KEY  = ROUND_KEY_DEFAULT,
   parameter  int unsigned      TAG_W      = 8,
   localparam int unsigned      OCC_W      = $clog2(NUM_ROUNDS + 3)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AES_W-1:0] in_key,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [AES_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy,
   output logic [OCC_W-1:0] occupancy
);

   logic             v [NUM_ROUNDS];
   logic [AES_W-1:0] d [NUM_ROUNDS];
   logic [TAG_W-1:0] t [NUM_ROUNDS];
   logic             adv;
   logic             accept;
   logic             deliver;

   for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_stage
      logic             v_prev;
      logic [AES_W-1:0] d_prev;
      logic [TAG_W-1:0] t_prev;
      if (i == 0) begin : g_head
         assign v_prev = in_valid;
         assign d_prev = in_key ^ ROUND_KEY;
         assign t_prev = in_tag;
      end else begin : g_body
         assign v_prev = v[i-1];
         assign d_prev = d[i-1];
         assign t_prev = t[i-1];
      end
      aes_round_stage #(.TAG_W(TAG_W)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .v_in  (v_prev),
         .d_in  (d_prev),
         .t_in  (t_prev),
         .key   (ROUND_KEY),
         .v_q   (v[i]),
         .d_q   (d[i]),
         .t_q   (t[i])
      );
   end

`ifdef AES_PIPE_SKID_EN
   logic [AES_W-1:0] skid_d [2];
   logic [TAG_W-1:0] skid_t [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       skid_cnt;
   logic             push;

   // Advance is decided from the registered FIFO count, cutting out_ready->in_ready.
   assign adv       = (skid_cnt != 2'd2);
   assign push      = adv & v[NUM_ROUNDS-1];
   assign out_valid = (skid_cnt != 2'd0);
   assign out_data  = skid_d[rd_ptr];
   assign out_tag   = skid_t[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_d[0] <= '0;
         skid_d[1] <= '0;
         skid_t[0] <= '0;
         skid_t[1] <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         skid_cnt  <= 2'd0;
      end else begin
         if (push) begin
            skid_d[wr_ptr] <= d[NUM_ROUNDS-1];
            skid_t[wr_ptr] <= t[NUM_ROUNDS-1];
            wr_ptr         <= ~wr_ptr;
         end
         if (deliver)
            rd_ptr <= ~rd_ptr;
         if (push && !deliver)
            skid_cnt <= skid_cnt + 2'd1;
         else if (!push && deliver)
            skid_cnt <= skid_cnt - 2'd1;
      end
   end
`else
   assign adv       = !v[NUM_ROUNDS-1] || out_ready;
   assign out_valid = v[NUM_ROUNDS-1];
   assign out_data  = d[NUM_ROUNDS-1];
   assign out_tag   = t[NUM_ROUNDS-1];
`endif

   assign in_ready = adv;
   assign accept   = in_valid & adv;
   assign deliver  = out_valid & out_ready;
   assign busy     = (occupancy != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occupancy <= '0;
      else if (accept && !deliver)
         occupancy <= occupancy + OCC_W'(1);
      else if (!accept && deliver)
         occupancy <= occupancy - OCC_W'(1);
   end

endmodule

// File: tb/tb_aes_round_pipe.sv
// Self-checking bench for aes_round_pipe: NUM_ROUNDS=30 main instance plus 1- and 64-round sweep instances.
// Reference model builds the S-box from GF(2^8) inverses and runs rounds on a 4x4 byte matrix.
module tb_aes_round_pipe;

   localparam int N = 30;
   localparam logic [127:0] RK = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a;
`ifdef AES_PIPE_SKID_EN
   localparam int EXTRA_LAT = 1;
   localparam int EXTRA_CAP = 2;
`else
   localparam int EXTRA_LAT = 0;
   localparam int EXTRA_CAP = 0;
`endif
   localparam int LAT = N + EXTRA_LAT;
   localparam int CAP = N + EXTRA_CAP;

   typedef struct packed {
      logic [127:0] key;
      logic [7:0]   tag;
   } item_t;

   logic         clk, rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_key, out_data;
   logic [7:0]   in_tag, out_tag;
   logic [5:0]   occupancy;

   logic         sw_in_valid, sw_out_ready;
   logic [127:0] sw_key;
   logic [7:0]   sw_tag;
   logic         a_in_ready, a_out_valid, a_busy;
   logic [127:0] a_out_data;
   logic [7:0]   a_out_tag;
   logic [1:0]   a_occ;
   logic         b_in_ready, b_out_valid, b_busy;
   logic [127:0] b_out_data;
   logic [7:0]   b_out_tag;
   logic [6:0]   b_occ;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sbox_ref [256];
   item_t q [$];

   aes_round_pipe #(.NUM_ROUNDS(N), .ROUND_KEY(RK), .TAG_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .busy(busy), .occupancy(occupancy));

   aes_round_pipe #(.NUM_ROUNDS(1), .ROUND_KEY(RK), .TAG_W(8)) dut_1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(a_in_ready), .in_key(sw_key),
      .in_tag(sw_tag), .out_valid(a_out_valid), .out_ready(sw_out_ready), .out_data(a_out_data),
      .out_tag(a_out_tag), .busy(a_busy), .occupancy(a_occ));

   aes_round_pipe #(.NUM_ROUNDS(64), .ROUND_KEY(RK), .TAG_W(8)) dut_64 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(b_in_ready), .in_key(sw_key),
      .in_tag(sw_tag), .out_valid(b_out_valid), .out_ready(sw_out_ready), .out_data(b_out_data),
      .out_tag(b_out_tag), .busy(b_busy), .occupancy(b_occ));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] xb, inv;
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (xb != 8'h00 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
         sbox_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] key, input int rounds);
      logic [7:0]   st  [4][4];
      logic [7:0]   tmp [4][4];
      logic [127:0] s;
      s = key ^ RK;
      for (int n = 0; n < rounds; n++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               st[r][c] = sbox_ref[s[127-8*(r+4*c) -: 8]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               tmp[r][c] = st[r][(c+r)%4];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[127-8*(r+4*c) -: 8] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c]) ^
                                       tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
         s = s ^ RK;
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_key = '0; in_tag = '0;
      sw_in_valid = 1'b0; sw_out_ready = 1'b0; sw_key = '0; sw_tag = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_checks++; if (out_tag !== 8'h00) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 00", out_tag); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (occupancy !== 6'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   // Accepts one item and watches the output window; returns first-valid cycle, payload and pulse count.
   task automatic run_single(input logic [127:0] key, input logic [7:0] tag, output int first,
                             output logic [127:0] got_d, output logic [7:0] got_t, output int pulses);
      @(negedge clk);
      in_valid = 1'b1; in_key = key; in_tag = tag; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got in_ready=%b expected 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      first = -1; pulses = 0; got_d = '0; got_t = '0;
      for (int k = 1; k <= LAT + 5; k++) begin
         #1;
         if (out_valid === 1'b1) begin
            pulses++;
            if (first < 0) begin first = k; got_d = out_data; got_t = out_tag; end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_item();
      int first, pulses;
      logic [127:0] d;
      logic [7:0]   t;
      run_single(128'h0, 8'h5a, first, d, t, pulses);
      n_checks++; if (first !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", first, LAT); end
      n_checks++; if (d !== model(128'h0, N)) begin n_fail++; $display("FAIL single_data: got %h expected %h", d, model(128'h0, N)); end
      n_checks++; if (t !== 8'h5a) begin n_fail++; $display("FAIL single_tag: got %h expected 5a", t); end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_back_to_back();
      int sent, got, peak, first_out, last_out;
      item_t e;
      q.delete();
      sent = 0; got = 0; peak = 0; first_out = -1; last_out = -1;
      for (int cyc = 0; cyc < 64 + LAT + 10 && got < 64; cyc++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (sent < 64);
         in_key    = 128'(sent);
         in_tag    = 8'(sent);
         #1;
         if (int'(occupancy) > peak) peak = int'(occupancy);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_checks++; n_fail++; $display("FAIL b2b_unexpected: got output tag %h expected none", out_tag);
            end else begin
               e = q.pop_front();
               n_checks++; if (out_tag !== e.tag) begin n_fail++; $display("FAIL b2b_tag: got %h expected %h", out_tag, e.tag); end
               n_checks++; if (out_data !== model(e.key, N)) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", out_data, model(e.key, N)); end
            end
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got++;
         end
         if (in_valid && in_ready) begin q.push_back('{key: in_key, tag: in_tag}); sent++; end
      end
      in_valid = 1'b0;
      n_checks++; if (got !== 64) begin n_fail++; $display("FAIL b2b_count: got %0d expected 64", got); end
      n_checks++; if (last_out - first_out !== 63) begin n_fail++; $display("FAIL b2b_span: got %0d expected 63", last_out - first_out); end
      n_checks++; if (peak !== LAT) begin n_fail++; $display("FAIL b2b_peak: got %0d expected %0d", peak, LAT); end
   endtask

   task automatic test_backpressure();
      int sent, got;
      item_t e;
      q.delete();
      sent = 0; got = 0;
      for (int cyc = 0; cyc < CAP + 20; cyc++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; in_key = rnd128(); in_tag = 8'(sent);
         #1;
         if (!in_ready) break;
         q.push_back('{key: in_key, tag: in_tag});
         sent++;
      end
      n_checks++; if (sent !== CAP) begin n_fail++; $display("FAIL bp_fill: got %0d expected %0d", sent, CAP); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_key = rnd128();
         #1;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
         n_checks++; if (int'(occupancy) !== CAP) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, CAP); end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
         n_checks++; if (out_tag !== q[0].tag) begin n_fail++; $display("FAIL bp_out_tag: got %h expected %h", out_tag, q[0].tag); end
         n_checks++; if (out_data !== model(q[0].key, N)) begin n_fail++; $display("FAIL bp_out_data: got %h expected %h", out_data, model(q[0].key, N)); end
      end
      for (int cyc = 0; cyc < CAP + 20 && q.size() > 0; cyc++) begin
         @(negedge clk);
         out_ready = 1'b1; in_valid = 1'b0;
         #1;
         if (out_valid) begin
            e = q.pop_front();
            got++;
            n_checks++; if (out_tag !== e.tag) begin n_fail++; $display("FAIL bp_drain_tag: got %h expected %h", out_tag, e.tag); end
            n_checks++; if (out_data !== model(e.key, N)) begin n_fail++; $display("FAIL bp_drain_data: got %h expected %h", out_data, model(e.key, N)); end
         end
      end
      n_checks++; if (got !== CAP) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got, CAP); end
      @(negedge clk);
      #1;
      n_checks++; if (busy !== 1'b0 || occupancy !== 6'd0) begin n_fail++; $display("FAIL bp_empty: got busy=%b occ=%0d expected 0/0", busy, occupancy); end
   endtask

   task automatic test_simultaneous();
      int got;
      bit seen;
      item_t e;
      q.delete();
      got = 0; seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1; in_key = rnd128(); in_tag = 8'(8'h80 + 8'(i));
         #1;
         if (in_ready) q.push_back('{key: in_key, tag: in_tag});
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int cyc = 0; cyc < LAT + 10; cyc++) begin
         #1;
         if (out_valid) begin seen = 1; break; end
         @(negedge clk);
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL sim_wait: got no out_valid expected one within %0d cycles", LAT + 10); end
      n_checks++; if (occupancy !== 6'd5) begin n_fail++; $display("FAIL sim_occ_before: got %0d expected 5", occupancy); end
      in_valid = 1'b1; in_key = rnd128(); in_tag = 8'h85; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sim_in_ready: got %b expected 1", in_ready); end
      if (out_valid && q.size() > 0) begin
         e = q.pop_front();
         got++;
         n_checks++; if (out_tag !== e.tag) begin n_fail++; $display("FAIL sim_tag: got %h expected %h", out_tag, e.tag); end
      end
      if (in_ready) q.push_back('{key: in_key, tag: in_tag});
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_checks++; if (occupancy !== 6'd5) begin n_fail++; $display("FAIL sim_occ_after: got %0d expected 5", occupancy); end
      for (int cyc = 0; cyc < LAT + 20 && q.size() > 0; cyc++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         if (out_valid) begin
            e = q.pop_front();
            got++;
            n_checks++; if (out_tag !== e.tag) begin n_fail++; $display("FAIL sim_drain_tag: got %h expected %h", out_tag, e.tag); end
            n_checks++; if (out_data !== model(e.key, N)) begin n_fail++; $display("FAIL sim_drain_data: got %h expected %h", out_data, model(e.key, N)); end
         end
      end
      n_checks++; if (got !== 6) begin n_fail++; $display("FAIL sim_count: got %0d expected 6", got); end
   endtask

   task automatic test_reset_midflight();
      int first, pulses;
      logic [127:0] key, d;
      logic [7:0]   t;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         out_ready = 1'b1; in_valid = 1'b1; in_key = rnd128(); in_tag = 8'(8'h40 + 8'(i));
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++; if (occupancy !== 6'd12) begin n_fail++; $display("FAIL rst_mid_occ_before: got %0d expected 12", occupancy); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (occupancy !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_occ: got occ=%0d busy=%b expected 0/0", occupancy, busy); end
      @(negedge clk);
      rst_n = 1'b1;
      key = rnd128();
      run_single(key, 8'hc3, first, d, t, pulses);
      n_checks++; if (first !== LAT) begin n_fail++; $display("FAIL rst_mid_latency: got %0d expected %0d", first, LAT); end
      n_checks++; if (d !== model(key, N)) begin n_fail++; $display("FAIL rst_mid_data: got %h expected %h", d, model(key, N)); end
      n_checks++; if (t !== 8'hc3) begin n_fail++; $display("FAIL rst_mid_tag: got %h expected c3", t); end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL rst_mid_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_param_sweep();
      item_t qa [$];
      item_t qb [$];
      item_t e;
      int sent_a, sent_b, got_a, got_b;
      sent_a = 0; sent_b = 0; got_a = 0; got_b = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         sw_in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
         sw_out_ready = (cyc >= 400) || ($urandom_range(0, 1) != 0);
         sw_key       = rnd128();
         sw_tag       = 8'(cyc);
         #1;
         n_checks++; if (int'(a_occ) !== qa.size() || a_busy !== (qa.size() != 0)) begin n_fail++; $display("FAIL sweep1_occ: got %0d expected %0d", a_occ, qa.size()); end
         n_checks++; if (int'(b_occ) !== qb.size() || b_busy !== (qb.size() != 0)) begin n_fail++; $display("FAIL sweep64_occ: got %0d expected %0d", b_occ, qb.size()); end
         if (a_out_valid && sw_out_ready) begin
            got_a++;
            if (qa.size() == 0) begin n_checks++; n_fail++; $display("FAIL sweep1_extra: got tag %h expected none", a_out_tag); end
            else begin
               e = qa.pop_front();
               n_checks++; if (a_out_tag !== e.tag || a_out_data !== model(e.key, 1)) begin n_fail++; $display("FAIL sweep1_item: got %h/%h expected %h/%h", a_out_tag, a_out_data, e.tag, model(e.key, 1)); end
            end
         end
         if (b_out_valid && sw_out_ready) begin
            got_b++;
            if (qb.size() == 0) begin n_checks++; n_fail++; $display("FAIL sweep64_extra: got tag %h expected none", b_out_tag); end
            else begin
               e = qb.pop_front();
               n_checks++; if (b_out_tag !== e.tag || b_out_data !== model(e.key, 64)) begin n_fail++; $display("FAIL sweep64_item: got %h/%h expected %h/%h", b_out_tag, b_out_data, e.tag, model(e.key, 64)); end
            end
         end
         if (sw_in_valid && a_in_ready) begin qa.push_back('{key: sw_key, tag: sw_tag}); sent_a++; end
         if (sw_in_valid && b_in_ready) begin qb.push_back('{key: sw_key, tag: sw_tag}); sent_b++; end
      end
      n_checks++; if (got_a !== sent_a || sent_a == 0) begin n_fail++; $display("FAIL sweep1_count: got %0d expected %0d", got_a, sent_a); end
      n_checks++; if (got_b !== sent_b || sent_b == 0) begin n_fail++; $display("FAIL sweep64_count: got %0d expected %0d", got_b, sent_b); end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_single_item();
      test_back_to_back();
      test_backpressure();
      test_simultaneous();
      test_reset_midflight();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
